// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM states, parity-mode constants and the bit-vote helper,
// shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: SYNC_STAGES-deep synchroniser for the asynchronous serial line.
// It resets to 1, the idle level, so that reset never produces a false start bit.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (!rst_n) stages <= '1;
    else        stages <= {stages[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with parity, framing and break reporting.
// Defining UART_RX_MAJORITY_EN votes each bit over three samples centred one clock later.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_RX,
  input  logic                 i_enable,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
  localparam int SHIFT = 1;
`else
  localparam int SHIFT = 0;
`endif
  localparam logic [CW-1:0] MID_CNT  = CW'((CLKS_PER_BIT - 1) / 2 + SHIFT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic rx_s, bit_val;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (i_Clock),
    .rst_n (i_Rst_n),
    .rx    (i_RX),
    .rx_s  (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) hist <= '1;
    else          hist <= {hist[0], rx_s};
  end
  assign bit_val = majority3(hist[1], hist[0], rx_s);
`else
  assign bit_val = rx_s;
`endif

  rx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
  logic                 par_err, par_err_n, ferr, ferr_n, zero, zero_n;
  logic                 dv_n, perr_out_n, ferr_out_n, brk_n;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt + CW'(1);
    idx_n      = idx;
    shreg_n    = shreg;
    par_err_n  = par_err;
    ferr_n     = ferr;
    zero_n     = zero;
    dv_n       = 1'b0;
    data_n     = o_RX_Data;
    perr_out_n = o_parity_err;
    ferr_out_n = o_frame_err;
    brk_n      = o_break;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (i_enable && !rx_s) state_n = START;
      end
      START: if (cnt == MID_CNT) begin
        cnt_n = '0;
        if (!bit_val) begin
          state_n   = DATA;
          idx_n     = '0;
          zero_n    = 1'b1;
          ferr_n    = 1'b0;
          par_err_n = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: if (cnt == LAST_CNT) begin
        cnt_n        = '0;
        shreg_n[idx] = bit_val;
        if (bit_val) zero_n = 1'b0;
        if (idx == IW'(DATA_BITS - 1)) begin
          idx_n   = '0;
          state_n = (PARITY != PAR_NONE) ? PAR : STOP;
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      PAR: if (cnt == LAST_CNT) begin
        cnt_n     = '0;
        par_err_n = (^shreg ^ bit_val) != (PARITY == PAR_ODD);
        if (bit_val) zero_n = 1'b0;
        state_n   = STOP;
      end
      STOP: if (cnt == LAST_CNT) begin
        cnt_n = '0;
        if (!bit_val) ferr_n = 1'b1;
        if (bit_val) zero_n = 1'b0;
        // The last stop sample is folded in directly so the flags publish on this edge.
        if (idx == IW'(STOP_BITS - 1)) begin
          idx_n      = '0;
          dv_n       = 1'b1;
          data_n     = shreg;
          perr_out_n = par_err;
          ferr_out_n = ferr | ~bit_val;
          brk_n      = zero & ~bit_val;
          state_n    = (ferr | ~bit_val) ? WAIT_HIGH : IDLE;
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      par_err      <= 1'b0;
      ferr         <= 1'b0;
      zero         <= 1'b0;
      o_RX_DV      <= 1'b0;
      o_RX_Data    <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      shreg        <= shreg_n;
      par_err      <= par_err_n;
      ferr         <= ferr_n;
      zero         <= zero_n;
      o_RX_DV      <= dv_n;
      o_RX_Data    <= data_n;
      o_parity_err <= perr_out_n;
      o_frame_err  <= ferr_out_n;
      o_break      <= brk_n;
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: two receivers (8N1 and 7E2, 16 clocks/bit) driven with a
// vector table, hand sequences for multi-cycle corners, and random frames.
module tb_uart_rx_cfg;

  localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic dv_a, perr_a, ferr_a, brk_a, busy_a;
  logic dv_b, perr_b, ferr_b, brk_b, busy_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_a (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_RX(rx_a), .i_enable(en),
    .o_RX_DV(dv_a), .o_RX_Data(data_a), .o_parity_err(perr_a),
    .o_frame_err(ferr_a), .o_break(brk_a), .o_busy(busy_a)
  );

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .SYNC_STAGES(2)) u_b (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_RX(rx_b), .i_enable(en),
    .o_RX_DV(dv_b), .o_RX_Data(data_b), .o_parity_err(perr_b),
    .o_frame_err(ferr_b), .o_break(brk_b), .o_busy(busy_b)
  );

  typedef struct {
    logic [8:0]  data;
    logic        perr;
    logic        ferr;
    logic        brk;
    int unsigned cyc;
  } obs_t;

  typedef struct {
    int         sel;
    logic [8:0] data;
    logic       pflip;
    logic [1:0] stops;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_brk;
  } vec_t;

  obs_t q_a[$];
  obs_t q_b[$];

  always @(negedge clk) begin
    if (dv_a) q_a.push_back('{{1'b0, data_a}, perr_a, ferr_a, brk_a, cyc});
    if (dv_b) q_b.push_back('{{2'b00, data_b}, perr_b, ferr_b, brk_b, cyc});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame length in clocks from start edge to last stop centre, plus sync and start detect.
  function automatic int unsigned frame_latency(input int sel);
    return 3 + (CPB - 1) / 2 + 1 + CPB * (sel != 0 ? 10 : 9) + MAJ;
  endfunction

  function automatic obs_t model(input int sel, input logic [8:0] data, input logic pflip,
                                 input logic [1:0] stops);
    obs_t r;
    int   ones;
    int   pbit;
    ones = 0;
    for (int i = 0; i < (sel != 0 ? 7 : 8); i++) ones += int'(data[i]);
    r.cyc = frame_latency(sel);
    if (sel == 0) begin
      r.data = {1'b0, data[7:0]};
      r.perr = 1'b0;
      r.ferr = !stops[0];
      r.brk  = (ones == 0) && !stops[0];
    end else begin
      r.data = {2'b00, data[6:0]};
      pbit   = (ones % 2) ^ int'(pflip);
      r.perr = ((ones + pbit) % 2) != 0;
      r.ferr = (stops != 2'b11);
      r.brk  = (ones == 0) && (pbit == 0) && (stops == 2'b00);
    end
    return r;
  endfunction

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  task automatic drive_bit(input int sel, input logic v);
    set_line(sel, v);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int sel, input int bits);
    set_line(sel, 1'b1);
    repeat (CPB * bits) @(negedge clk);
  endtask

  // Leaves the line at the last stop level; the caller restores idle.
  task automatic send_frame(input int sel, input logic [8:0] data, input logic pflip,
                            input logic [1:0] stops, output int unsigned c0);
    logic par;
    c0 = cyc;
    drive_bit(sel, 1'b0);
    for (int i = 0; i < (sel != 0 ? 7 : 8); i++) drive_bit(sel, data[i]);
    if (sel != 0) begin
      par = ^data[6:0] ^ pflip;
      drive_bit(sel, par);
    end
    drive_bit(sel, stops[0]);
    if (sel != 0) drive_bit(sel, stops[1]);
  endtask

  task automatic check_frame(input int sel, input string name, input logic [8:0] ed,
                             input logic ep, input logic ef, input logic eb, input int unsigned c0);
    obs_t o;
    int   n;
    n = (sel != 0) ? q_b.size() : q_a.size();
    chk({name, " dv_count"}, n, 1);
    if (n > 0) begin
      if (sel != 0) o = q_b.pop_front();
      else          o = q_a.pop_front();
      chk({name, " data"}, o.data, ed);
      chk({name, " parity_err"}, o.perr, ep);
      chk({name, " frame_err"}, o.ferr, ef);
      chk({name, " break"}, o.brk, eb);
      chk({name, " latency"}, o.cyc - c0, frame_latency(sel));
    end
    if (sel != 0) q_b.delete();
    else          q_a.delete();
    chk({name, " busy_after"}, (sel != 0) ? busy_b : busy_a, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  vec_t        vecs[10];
  int unsigned c0;
  int          sel;
  logic [8:0]  rdata;
  logic        rflip;
  logic [1:0]  rstops;
  logic        saw_busy;
  obs_t        e;

  initial begin
    vecs[0] = '{0, 9'h03F, 1'b0, 2'b11, 9'h03F, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{0, 9'h000, 1'b0, 2'b10, 9'h000, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{0, 9'h080, 1'b0, 2'b10, 9'h080, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1, 9'h055, 1'b1, 2'b11, 9'h055, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1, 9'h02A, 1'b0, 2'b01, 9'h02A, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1, 9'h000, 1'b0, 2'b00, 9'h000, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{1, 9'h07F, 1'b1, 2'b11, 9'h07F, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{1, 9'h000, 1'b1, 2'b00, 9'h000, 1'b1, 1'b1, 1'b0};

    repeat (4) @(negedge clk);
    chk("reset dv_a", dv_a, 1'b0);
    chk("reset data_a", data_a, 8'h00);
    chk("reset flags_a", {perr_a, ferr_a, brk_a}, 3'b000);
    chk("reset busy_a", busy_a, 1'b0);
    chk("reset dv_b", dv_b, 1'b0);
    chk("reset data_b", data_b, 7'h00);
    chk("reset flags_b", {perr_b, ferr_b, brk_b}, 3'b000);
    chk("reset busy_b", busy_b, 1'b0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].sel, vecs[i].data, vecs[i].pflip, vecs[i].stops, c0);
      idle(vecs[i].sel, 2);
      check_frame(vecs[i].sel, $sformatf("vec%0d", i), vecs[i].exp_data,
                  vecs[i].exp_perr, vecs[i].exp_ferr, vecs[i].exp_brk, c0);
    end

    // Break: 12 bit times low gives one frame, then the receiver parks until the line rises.
    c0 = cyc;
    rx_a = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    chk("break holds busy", busy_a, 1'b1);
    idle(0, 2);
    check_frame(0, "break", 9'h000, 1'b0, 1'b1, 1'b1, c0);

    send_frame(1, 9'h02A, 1'b0, 2'b01, c0);
    repeat (3 * CPB) @(negedge clk);
    chk("wait_high busy_b", busy_b, 1'b1);
    idle(1, 2);
    check_frame(1, "wait_high", 9'h02A, 1'b0, 1'b1, 1'b0, c0);

    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
    saw_busy = 1'b0;
    repeat (20) @(negedge clk) if (busy_a) saw_busy = 1'b1;
    chk("glitch busy pulse", saw_busy, 1'b1);
    chk("glitch no dv", q_a.size(), 0);
    chk("glitch busy_after", busy_a, 1'b0);

    rx_a = 1'b0;
    repeat (CPB) @(negedge clk);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    rst_n = 1'b0;
    rx_a  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("midreset busy", busy_a, 1'b0);
    chk("midreset no dv", q_a.size(), 0);
    idle(0, 2);
    send_frame(0, 9'h0A5, 1'b0, 2'b11, c0);
    idle(0, 2);
    check_frame(0, "after_reset", 9'h0A5, 1'b0, 1'b0, 1'b0, c0);

    fork
      send_frame(0, 9'h0C3, 1'b0, 2'b11, c0);
      begin
        repeat (3 * CPB) @(negedge clk);
        en = 1'b0;
      end
    join
    idle(0, 2);
    check_frame(0, "enable_drop", 9'h0C3, 1'b0, 1'b0, 1'b0, c0);
    send_frame(0, 9'h011, 1'b0, 2'b11, c0);
    idle(0, 2);
    chk("disabled no dv", q_a.size(), 0);
    chk("disabled busy", busy_a, 1'b0);
    en = 1'b1;

`ifdef UART_RX_MAJORITY_EN
    // One-clock dropout at the centre of data bit 2 must be outvoted.
    c0 = cyc;
    rdata = 9'h03F;
    for (int b = 0; b < 10; b++) begin
      rflip = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : rdata[b-1];
      if (b == 3) begin
        rx_a = rflip;
        repeat (8) @(negedge clk);
        rx_a = ~rflip;
        @(negedge clk);
        rx_a = rflip;
        repeat (7) @(negedge clk);
      end else begin
        drive_bit(0, rflip);
      end
    end
    idle(0, 2);
    check_frame(0, "majority_glitch", 9'h03F, 1'b0, 1'b0, 1'b0, c0);
`endif

    for (int k = 0; k < 40; k++) begin
      sel    = int'($urandom_range(0, 1));
      rdata  = 9'($urandom);
      if ($urandom_range(0, 7) == 0) rdata = '0;
      rflip  = ($urandom_range(0, 3) == 0);
      rstops = {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)};
      e = model(sel, rdata, rflip, rstops);
      send_frame(sel, rdata, rflip, rstops, c0);
      idle(sel, int'($urandom_range(2, 3)));
      check_frame(sel, $sformatf("rand%0d", k), e.data, e.perr, e.ferr, e.brk, c0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
